// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte-stream front end: ASCII codes,
// parser states and the per-byte character classification.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_DISCARD = 2'd2
  } parser_state_t;

  typedef struct packed {
    logic       is_hex;
    logic       is_term;
    logic       is_space;
    logic [3:0] nibble;
  } char_class_t;

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational classifier: maps one received byte to hex/terminator/space
// flags plus the hex nibble value (case-insensitive).
module ascii_hex_decode
  import uart_pkg::*;
(
  input  logic [7:0]  rx_data,
  output char_class_t cls
);

  always_comb begin
    cls = '0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      cls.is_hex = 1'b1;
      cls.nibble = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 lands on 0xA
      cls.is_hex = 1'b1;
      cls.nibble = rx_data[3:0] + 4'd9;
    end
    cls.is_term  = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
    cls.is_space = (rx_data == ASCII_SP);
  end

endmodule

// File: rtl/uart_hex_parser.sv
// Assembles ASCII hex digits from the UART receiver into a word, emitted on
// CR/LF; malformed lines are dropped and flagged. Never stalls the receiver.
module uart_hex_parser
  import uart_pkg::*;
#(
  parameter  int MAX_DIGITS = 4,
  localparam int W          = 4 * MAX_DIGITS,
  localparam int CW         = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic [W-1:0]  value,
  output logic [CW-1:0] value_digits,
  output logic          value_valid,
  output logic          parse_err
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);

  parser_state_t state_reg;
  logic [W-1:0]  acc_reg;
  logic [CW-1:0] cnt_reg;
  char_class_t   cls;
  logic [W-1:0]  acc_shift;

  ascii_hex_decode u_decode (
    .rx_data (rx_data),
    .cls     (cls)
  );

  // A single-digit configuration has nothing to shift out of the way.
  generate
    if (W > 4) begin : g_shift
      assign acc_shift = {acc_reg[W-5:0], cls.nibble};
    end else begin : g_no_shift
      assign acc_shift = cls.nibble;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      value        <= '0;
      value_digits <= '0;
      value_valid  <= 1'b0;
      parse_err    <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      parse_err   <= 1'b0;
      if (rx_valid) begin
        case (state_reg)
          ST_IDLE: begin
            if (cls.is_hex) begin
              acc_reg   <= W'(cls.nibble);
              cnt_reg   <= CW'(1);
              state_reg <= ST_ACCUM;
            end else if (!cls.is_term && !cls.is_space) begin
              state_reg <= ST_DISCARD;
            end
          end
          ST_ACCUM: begin
            if (cls.is_hex) begin
              if (cnt_reg == MAX_CNT) begin
                state_reg <= ST_DISCARD;
              end else begin
                acc_reg <= acc_shift;
                cnt_reg <= cnt_reg + CW'(1);
              end
            end else if (cls.is_term) begin
              value        <= acc_reg;
              value_digits <= cnt_reg;
              value_valid  <= 1'b1;
              acc_reg      <= '0;
              cnt_reg      <= '0;
              state_reg    <= ST_IDLE;
            end else begin
              state_reg <= ST_DISCARD;
            end
          end
          ST_DISCARD: begin
            if (cls.is_term) begin
              parse_err <= 1'b1;
              acc_reg   <= '0;
              cnt_reg   <= '0;
              state_reg <= ST_IDLE;
            end
          end
          default: begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_hex_parser.sv
// Directed plus randomized line stimulus for uart_hex_parser, checked against
// a line-level reference model that judges each whole line on its terminator.
module tb_uart_hex_parser;

  localparam int MAX_DIGITS = 4;
  localparam int W          = 4 * MAX_DIGITS;
  localparam int CW         = $clog2(MAX_DIGITS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [W-1:0]  value;
  logic [CW-1:0] value_digits;
  logic          value_valid;
  logic          parse_err;

  int errors = 0;
  int checks = 0;

  // Model state: bytes of the current line, and the last accepted word.
  byte unsigned line_q[$];
  int unsigned  exp_value  = 0;
  int unsigned  exp_digits = 0;
  string        hex_chars  = "0123456789abcdefABCDEF";

  uart_hex_parser #(.MAX_DIGITS(MAX_DIGITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .value        (value),
    .value_digits (value_digits),
    .value_valid  (value_valid),
    .parse_err    (parse_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int hex_index(input byte unsigned c);
    for (int i = 0; i < hex_chars.len(); i++)
      if (hex_chars[i] == c) return (i < 16) ? i : i - 6;
    return -1;
  endfunction

  // Judge a completed line: 0 = nothing, 1 = word accepted, 2 = error.
  task automatic judge_line(output int verdict);
    int first;
    int n;
    int unsigned v;
    first = 0;
    while (first < line_q.size() && line_q[first] == 8'h20) first++;
    n = line_q.size() - first;
    verdict = 1;
    v = 0;
    if (n == 0) verdict = 0;
    else if (n > MAX_DIGITS) verdict = 2;
    else begin
      for (int i = first; i < line_q.size(); i++) begin
        if (hex_index(line_q[i]) < 0) verdict = 2;
        else v = v * 16 + hex_index(line_q[i]);
      end
    end
    if (verdict == 1) begin
      exp_value  = v;
      exp_digits = n;
    end
    line_q.delete();
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic ep);
    chk({tag, ".valid"}, 32'(value_valid), 32'(ev));
    chk({tag, ".err"}, 32'(parse_err), 32'(ep));
    chk({tag, ".value"}, 32'(value), exp_value);
    chk({tag, ".digits"}, 32'(value_digits), exp_digits);
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs settled.
  task automatic send_byte(input byte unsigned b);
    int verdict;
    verdict = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    if (b == 8'h0D || b == 8'h0A) judge_line(verdict);
    else line_q.push_back(b);
    $display("byte %02h -> valid=%0b err=%0b value=%04h digits=%0d",
             b, value_valid, parse_err, value, value_digits);
    check_outputs($sformatf("byte_%02h", b), verdict == 1, verdict == 2);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs("idle", 1'b0, 1'b0);
    end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      if (gap > 0) idle(gap);
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    byte unsigned bad_chars[5];
    byte unsigned c;
    int len;
    int r;
    bad_chars = '{8'h47, 8'h78, 8'h2E, 8'h00, 8'hFF};

    repeat (2) @(negedge clk);
    check_outputs("reset", 1'b0, 1'b0);
    rst = 1'b0;

    // Blank lines only: nothing happens, outputs keep reset values.
    send_str("\r\n\r\n", 0);
    idle(2);

    send_str("1A3F\r", 0);
    idle(2);
    send_str("b\r\n", 10);
    send_str("12G4\r", 0);
    idle(1);
    send_str("12345\r", 0);
    send_str("  7\n", 0);
    idle(1);
    send_str("ffff\ra", 0);
    send_str("\n", 0);
    idle(1);

    // Randomized lines with mixed digits, spaces, junk and gaps.
    for (int l = 0; l < 60; l++) begin
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r <= 6) c = hex_chars[$urandom_range(0, 21)];
        else if (r == 7) c = 8'h20;
        else if (r == 8) c = bad_chars[$urandom_range(0, 4)];
        else c = $urandom_range(0, 255);
        send_byte(c);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      send_byte(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);

    // Reset mid-line: partial "12" is lost, no pulse, value returns to 0.
    send_str("12", 0);
    rst = 1'b1;
    line_q.delete();
    exp_value  = 0;
    exp_digits = 0;
    idle(2);
    rst = 1'b0;
    send_str("3\r", 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
